// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared types and constants for the AES stream controller.
package aes_stream_pkg;
  localparam int AES_BYTE_W = 8;
  localparam int DEF_BLOCK_BYTES = 16;
  typedef enum logic [1:0] {IDLE, LOAD, COLLECT, DRAIN} state_t;
endpackage

// File: rtl/aes_stream_ctrl_if.sv
// aes_stream_ctrl_if: FIFO and byte-wide AES core signals seen by the stream controller.
interface aes_stream_ctrl_if #(parameter int DATA_WIDTH = 16);
  logic data_empty;
  logic [DATA_WIDTH-1:0] data_din;
  logic data_rd;
  logic data_full;
  logic data_wr;
  logic [DATA_WIDTH-1:0] data_dout;
  logic aes_load;
  logic [aes_stream_pkg::AES_BYTE_W-1:0] aes_key;
  logic [aes_stream_pkg::AES_BYTE_W-1:0] aes_din;
  logic [aes_stream_pkg::AES_BYTE_W-1:0] aes_dout;
  logic aes_vld;
  logic aes_abort;
  modport master (
    input  data_empty, data_din, data_full, aes_dout, aes_vld,
    output data_rd, data_wr, data_dout, aes_load, aes_key, aes_din, aes_abort
  );
  modport slave (
    output data_empty, data_din, data_full, aes_dout, aes_vld,
    input  data_rd, data_wr, data_dout, aes_load, aes_key, aes_din, aes_abort
  );
endinterface

// File: rtl/aes_stream_obuf.sv
// aes_stream_obuf: per-block result byte buffer, one write port and a combinational read, same index.
module aes_stream_obuf
  import aes_stream_pkg::*;
#(
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic clock,
  input  logic we,
  input  logic [3:0] idx,
  input  logic [AES_BYTE_W-1:0] wdata,
  output logic [AES_BYTE_W-1:0] rdata
);
  logic [AES_BYTE_W-1:0] mem [BLOCK_BYTES];
  always_ff @(posedge clock)
    if (we) mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: streams FIFO words into a byte-wide AES core, buffers the result block and drains it.
// Define AES_STREAM_CTRL_TIMEOUT_EN to build the COLLECT watchdog (aes_abort / err_timeout).
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic rst,
  aes_stream_ctrl_if.master io,
  output logic busy,
  output logic [15:0] blk_cnt,
  output logic err_timeout
);
  localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);
  state_t state, state_nx;
  logic [3:0] idx;
  logic [15:0] blk_cnt_q;
  logic [AES_BYTE_W-1:0] rd_byte;
  logic last, vld, adv, timeout;
  assign last = idx == LAST;
  assign vld = state == COLLECT && io.aes_vld;
  assign busy = state != IDLE;
  assign blk_cnt = blk_cnt_q;
  assign io.aes_key = io.data_din[15:8];
  assign io.aes_din = io.data_din[7:0];
  assign io.data_dout = DATA_WIDTH'(rd_byte);
  always_comb begin
    io.data_rd = state == LOAD && !io.data_empty;
    io.aes_load = state == LOAD && !io.data_empty;
    io.data_wr = state == DRAIN && !io.data_full;
    adv = io.data_rd || vld || io.data_wr;
    state_nx = state;
    case (state)
      IDLE:    state_nx = io.data_empty ? IDLE : LOAD;
      LOAD:    state_nx = io.data_rd && last ? COLLECT : LOAD;
      COLLECT: state_nx = vld && last ? DRAIN : timeout ? IDLE : COLLECT;
      DRAIN:   state_nx = io.data_wr && last ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // idx sits at zero in IDLE, so each block starts loading from byte 0
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      blk_cnt_q <= '0;
    end else begin
      state <= state_nx;
      idx <= (state == IDLE || timeout || (adv && last)) ? '0 : idx + 4'(adv);
      if (io.data_wr && last) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  aes_stream_obuf #(.BLOCK_BYTES(BLOCK_BYTES)) u_obuf (
    .clock(clock),
    .we(vld),
    .idx(idx),
    .wdata(io.aes_dout),
    .rdata(rd_byte)
  );
`ifdef AES_STREAM_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;
  assign timeout = state == COLLECT && !io.aes_vld && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign io.aes_abort = timeout;
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      to_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      to_cnt <= (state != COLLECT || io.aes_vld) ? '0 : to_cnt + 1'b1;
      if (timeout) err_timeout <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign io.aes_abort = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: randomized FIFO/core environment with a queue-based block model.
module tb_aes_stream_ctrl;
  localparam int N = 16;
  localparam int TO = 8;
  logic clock = 0;
  logic rst = 0;
  logic busy, err_timeout;
  logic [15:0] blk_cnt;
  aes_stream_ctrl_if #(.DATA_WIDTH(16)) io ();
  aes_stream_ctrl #(.DATA_WIDTH(16), .BLOCK_BYTES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .rst(rst),
    .io(io),
    .busy(busy),
    .blk_cnt(blk_cnt),
    .err_timeout(err_timeout)
  );
  always #5 clock = ~clock;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] in_q[$];
  logic [7:0] pend_q[$], res_q[$], exp_q[$];
  int emit_cnt = 0, core_limit = N, in_hold = 0, full_hold = 0, full_at = -1, gap_at = -1;
  int pushes = 0, loads = 0, busy_cyc = 0, last_vld_cyc = 0, abort_cyc = 0, abort_n = 0;
  bit rnd = 0, junk = 0, vld_real = 0;
  logic [15:0] exp_blk = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    io.data_empty = in_hold > 0 || in_q.size() == 0 || (rnd && $urandom_range(3) == 0);
    if (in_hold > 0) in_hold--;
    io.data_din = in_q.size() > 0 ? in_q[0] : 16'($urandom);
    io.data_full = full_hold > 0 || (rnd && $urandom_range(3) == 0);
    if (full_hold > 0) full_hold--;
    vld_real = res_q.size() > 0 && emit_cnt < core_limit && (!rnd || $urandom_range(3) != 0);
    io.aes_vld = vld_real || (junk && res_q.size() == 0 && $urandom_range(7) == 0);
    io.aes_dout = vld_real ? res_q[0] : 8'($urandom);
    @(negedge clock);
    if (busy) busy_cyc++;
    check("rd_eq_load", io.aes_load, io.data_rd);
    if (io.data_empty) check("rd_when_empty", io.data_rd, 0);
    if (io.data_full) check("wr_when_full", io.data_wr, 0);
`ifndef AES_STREAM_CTRL_TIMEOUT_EN
    check("abort_tied", {io.aes_abort, err_timeout}, 0);
`endif
    if (res_q.size() == 0 && exp_q.size() > 0) begin
      check("dout", io.data_dout, {8'h00, exp_q[0]});
      check("wr_strobe", io.data_wr, !io.data_full);
    end
    if (io.aes_load) begin
      if (in_q.size() == 0) check("load_unexpected", io.aes_load, 0);
      else begin
        check("load_word", {io.aes_key, io.aes_din}, in_q[0]);
        pend_q.push_back(in_q[0][15:8] ^ in_q[0][7:0]);
        void'(in_q.pop_front());
        loads++;
        if (pend_q.size() == gap_at) in_hold = 5;
        if (pend_q.size() == N) begin
          res_q = pend_q;
          exp_q = pend_q;
          pend_q.delete();
          emit_cnt = 0;
        end
      end
    end
    if (vld_real) begin
      void'(res_q.pop_front());
      emit_cnt++;
      last_vld_cyc = cyc;
    end
    if (io.data_wr) begin
      if (exp_q.size() == 0) check("push_unexpected", io.data_wr, 0);
      else begin
        check("push_phase", res_q.size(), 0);
        void'(exp_q.pop_front());
        pushes++;
        if (exp_q.size() == 0) exp_blk++;
        if (N - exp_q.size() == full_at) full_hold = 10;
      end
    end
    if (io.aes_abort) begin
      abort_n++;
      abort_cyc = cyc;
      res_q.delete();
      exp_q.delete();
    end
  endtask
  task automatic fill(input bit fixed);
    for (int i = 0; i < N; i++) begin
      logic [7:0] k;
      k = 8'($urandom);
      in_q.push_back(fixed ? {k, k ^ 8'(i)} : 16'($urandom));
    end
  endtask
  task automatic run_block(input bit fixed, output int bc);
    int p0, l0, b0, t;
    p0 = pushes; l0 = loads; b0 = busy_cyc; t = 0;
    fill(fixed);
    while ((pushes - p0 < N || busy) && t < 3000) begin
      step();
      t++;
    end
    check("blk_in_budget", t < 3000, 1);
    check("blk_loads", loads - l0, N);
    check("blk_pushes", pushes - p0, N);
    check("blk_cnt", blk_cnt, exp_blk);
    bc = busy_cyc - b0;
  endtask
  initial begin
    int bc, t, a0, p0, l0;
    io.data_empty = 0; io.data_din = 16'h1234; io.data_full = 0;
    io.aes_vld = 1; io.aes_dout = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes", {io.data_rd, io.aes_load, io.data_wr, io.aes_abort}, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_err", err_timeout, 0);
    io.data_empty = 1; io.aes_vld = 0;
    @(negedge clock);
    rst = 1;
    run_block(1, bc);
    check("throughput_busy", bc, 3 * N);
    gap_at = 7;
    run_block(1, bc);
    gap_at = -1;
    full_at = 4;
    run_block(0, bc);
    full_at = -1;
    rnd = 1; junk = 1;
    repeat (12) run_block(0, bc);
    rnd = 0; junk = 0;
    core_limit = 3; a0 = abort_n; p0 = pushes; t = 0;
    fill(0);
`ifdef AES_STREAM_CTRL_TIMEOUT_EN
    while (abort_n == a0 && t < 300) begin step(); t++; end
    check("abort_seen", abort_n - a0, 1);
    check("abort_delay", abort_cyc - last_vld_cyc, TO);
    repeat (3) step();
    check("abort_single", abort_n - a0, 1);
    check("err_sticky", err_timeout, 1);
    check("abort_idle", busy, 0);
    check("abort_blk_cnt", blk_cnt, exp_blk);
    check("abort_no_push", pushes - p0, 0);
    core_limit = N;
    run_block(0, bc);
    check("err_still_set", err_timeout, 1);
`else
    repeat (60) step();
    check("stall_busy", busy, 1);
    check("stall_no_push", pushes - p0, 0);
    core_limit = N;
    while ((pushes - p0 < N || busy) && t < 300) begin step(); t++; end
    check("stall_resume_pushes", pushes - p0, N);
    check("stall_blk_cnt", blk_cnt, exp_blk);
`endif
    l0 = loads; t = 0;
    fill(0);
    while (loads - l0 < 9 && t < 200) begin step(); t++; end
    check("pre_reset_loads", loads - l0, 9);
    @(posedge clock);
    #1;
    io.data_empty = 0;
    rst = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {io.data_rd, io.aes_load, io.data_wr}, 0);
    check("mid_rst_blk_cnt", blk_cnt, 0);
    check("mid_rst_err", err_timeout, 0);
    in_q.delete(); pend_q.delete(); res_q.delete(); exp_q.delete();
    exp_blk = 0;
    io.data_empty = 1;
    @(negedge clock);
    rst = 1;
    run_block(0, bc);
    check("after_rst_blk", blk_cnt, 1);
    force dut.blk_cnt_q = 16'hFFFF;
    #1;
    release dut.blk_cnt_q;
    exp_blk = 16'hFFFF;
    check("wrap_pre", blk_cnt, 16'hFFFF);
    run_block(1, bc);
    check("wrap_post", blk_cnt, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
